// File: rtl/spi_master_frame_if.sv
// Frame-level handshake and SPI pin bundle for spi_master_frame.
// master modport is the SPI master's view; slave modport is the controller/pin side.
interface spi_master_frame_if #(
    parameter int unsigned FRAME_BITS = 32
);
    logic                  start;
    logic [FRAME_BITS-1:0] d;
    logic [FRAME_BITS-1:0] q;
    logic                  done;
    logic                  busy;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  start, d, miso,
        output q, done, busy, sck, mosi, cs_n
    );

    modport slave (
        output start, d, miso,
        input  q, done, busy, sck, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_frame.sv
// Mode-0 SPI master: full-duplex FRAME_BITS frames, MSB first, sck = f_clk/(2*CLK_DIV).
// All outputs are registered; done is a single-cycle pulse at the last sck fall.
module spi_master_frame #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FRAME_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_frame_if.master bus
);
    localparam int unsigned CNT_W    = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            div_q, div_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] q_q, q_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        q_d     = q_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.d;
                    mosi_d  = bus.d[FRAME_BITS-1];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end

            LOW: begin
                if (div_q == DIV_LAST) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[FRAME_BITS-2:0], bus.miso};
                    div_d   = '0;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            HIGH: begin
                if (div_q == DIV_LAST) begin
                    sck_d = 1'b0;
                    div_d = '0;
                    if (cnt_q != BIT_LAST) begin
                        cnt_d   = cnt_q + 1'b1;
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_q[FRAME_BITS-2];
                        state_d = LOW;
                    end else begin
                        q_d    = rx_q;
                        done_d = 1'b1;
                        // start at the final fall chains the next frame on this same edge,
                        // so cs_n never rises and sck keeps its cadence across the boundary
                        if (bus.start) begin
                            tx_d    = bus.d;
                            mosi_d  = bus.d[FRAME_BITS-1];
                            cnt_d   = '0;
                            state_d = LOW;
                        end else begin
                            busy_d  = 1'b0;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            q_q     <= q_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.sck  = sck_q;
    assign bus.mosi = mosi_q;
    assign bus.cs_n = cs_n_q;
endmodule
